// File: rtl/hex_lcd_pkg.sv
// Shared types and ASCII constants for the LCD hex field formatter.
package hex_lcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    REQ  = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A_LC  = 8'h61;
  localparam logic [7:0] ASCII_A_UC  = 8'h41;

endpackage

// File: rtl/hex_ascii.sv
// Nibble to ASCII hex digit.
//   nib   : 4-bit value
//   chr_c : ASCII character, letters upper case when UPPER=1
module hex_ascii
  import hex_lcd_pkg::*;
#(
  parameter bit UPPER = 1'b0
) (
  input  logic [3:0] nib,
  output logic [7:0] chr_c
);

  localparam logic [7:0] BASE = UPPER ? ASCII_A_UC : ASCII_A_LC;

  always_comb begin
    chr_c = ASCII_0 + 8'(nib);
    if (nib >= 4'd10) chr_c = BASE + 8'(nib - 4'd10);
  end

endmodule

// File: rtl/hex_lcd_formatter.sv
// Renders changed channels as hex into the LCD string, one digit per
// cycle, then requests a single LCD refresh per batch of conversions.
//   clk, rst      : clock, asynchronous active-low reset
//   ch_data       : NCH channel values, channel 0 in the top DW bits
//   ch_en         : per-channel render enable (bit c = channel c)
//   force_redraw  : one-cycle pulse, redraw every enabled channel
//   disp_busy     : LCD driver busy, refresh request withheld while high
//   strdata       : display string, char 0 in the top byte
//   cls           : one-cycle refresh request
//   fmt_busy      : formatter not idle
module hex_lcd_formatter
  import hex_lcd_pkg::*;
#(
  parameter int unsigned      NCH   = 4,
  parameter int unsigned      DW    = 32,
  parameter int unsigned      NCHAR = 32,
  // Four 8-digit fields tiling the two 16-char rows.
  parameter logic [NCH*8-1:0] POS   = {8'd0, 8'd8, 8'd16, 8'd24},
  parameter bit               UPPER = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH*DW-1:0]   ch_data,
  input  logic [NCH-1:0]      ch_en,
  input  logic                force_redraw,
  input  logic                disp_busy,
  output logic [NCHAR*8-1:0]  strdata,
  output logic                cls,
  output logic                fmt_busy
);

  localparam int unsigned ND = DW / 4;
  localparam int unsigned KW = (ND > 1) ? $clog2(ND) : 1;
  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

  // Parameter sanity: digit-aligned width, fields inside the string, no overlap.
  if (DW % 4 != 0) begin : g_dw_chk
    $error("DW must be a multiple of 4");
  end
  for (genvar a = 0; a < NCH; a++) begin : g_pos_chk
    localparam int PA = int'(POS[(NCH-1-a)*8 +: 8]);
    if (PA + int'(ND) > int'(NCHAR)) begin : g_range
      $error("field of channel %0d exceeds the display string", a);
    end
    for (genvar b = a + 1; b < NCH; b++) begin : g_ovl
      localparam int PB = int'(POS[(NCH-1-b)*8 +: 8]);
      if (PA < PB + int'(ND) && PB < PA + int'(ND)) begin : g_hit
        $error("fields of channels %0d and %0d overlap", a, b);
      end
    end
  end

  state_t          state;
  logic [DW-1:0]   snap [NCH];
  logic [NCH-1:0]  pend;
  logic [CW-1:0]   cur;
  logic [KW-1:0]   k;

  logic [DW-1:0]   ch_c [NCH];
  logic [NCH-1:0]  dirty_c;
  logic [NCH-1:0]  pend_nxt_c;
  logic            any_dirty_c;
  logic [CW-1:0]   pick_c;
  logic            latch_c;
  logic [DW-1:0]   cur_snap_c;
  logic [7:0]      pos_c;
  logic [7:0]      idx_c;
  logic [3:0]      nib_c;
  logic [7:0]      chr_c;

  // Dirty tracking, lowest-index pick and pending-redraw update.
  always_comb begin
    any_dirty_c = 1'b0;
    pick_c      = '0;
    for (int c = 0; c < NCH; c++) begin
      ch_c[c]    = ch_data[(NCH-1-c)*DW +: DW];
      dirty_c[c] = ch_en[c] & (pend[c] | (ch_c[c] != snap[c]));
    end
    for (int c = NCH - 1; c >= 0; c--) begin
      if (dirty_c[c]) begin
        any_dirty_c = 1'b1;
        pick_c      = CW'(c);
      end
    end
    latch_c = any_dirty_c &
              ((state == IDLE) || ((state == CONV) && (k == KW'(ND - 1))));
    // A force in the latch cycle re-arms the channel being latched.
    for (int c = 0; c < NCH; c++) begin
      pend_nxt_c[c] = (pend[c] & ~(latch_c && (pick_c == CW'(c)))) |
                      (ch_en[c] & force_redraw);
    end
  end

  // Current digit and its character position.
  always_comb begin
    cur_snap_c = '0;
    pos_c      = '0;
    nib_c      = '0;
    for (int c = 0; c < NCH; c++) begin
      if (cur == CW'(c)) begin
        cur_snap_c = snap[c];
        pos_c      = POS[(NCH-1-c)*8 +: 8];
      end
    end
    for (int d = 0; d < ND; d++) begin
      if (k == KW'(d)) nib_c = cur_snap_c[(ND-1-d)*4 +: 4];
    end
    idx_c = pos_c + 8'(k);
  end

  hex_ascii #(.UPPER(UPPER)) u_hex_ascii (
    .nib   (nib_c),
    .chr_c (chr_c)
  );

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      strdata  <= {NCHAR{ASCII_SPACE}};
      cls      <= 1'b0;
      fmt_busy <= 1'b0;
      pend     <= '0;
      cur      <= '0;
      k        <= '0;
      for (int c = 0; c < NCH; c++) snap[c] <= '0;
    end else begin
      cls  <= 1'b0;
      pend <= pend_nxt_c;
      if (latch_c) begin
        for (int c = 0; c < NCH; c++) begin
          if (pick_c == CW'(c)) snap[c] <= ch_c[c];
        end
      end
      case (state)
        IDLE: begin
          if (any_dirty_c) begin
            cur      <= pick_c;
            k        <= '0;
            state    <= CONV;
            fmt_busy <= 1'b1;
          end
        end
        CONV: begin
          for (int i = 0; i < NCHAR; i++) begin
            if (idx_c == 8'(i)) strdata[(NCHAR-1-i)*8 +: 8] <= chr_c;
          end
          if (k == KW'(ND - 1)) begin
            // Chain the next dirty channel into the same batch.
            if (any_dirty_c) begin
              cur <= pick_c;
              k   <= '0;
            end else begin
              state <= REQ;
            end
          end else begin
            k <= k + KW'(1);
          end
        end
        REQ: begin
          if (!disp_busy) begin
            cls      <= 1'b1;
            state    <= IDLE;
            fmt_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          fmt_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
